fmult_pipe: RTL

- Parametrised, pipelined IEEE-754-style floating-point multiplier.
- Successor to the team's single-cycle combinational multiplier, with these additions:
  - configurable exponent and mantissa widths;
  - full leading-zero normalisation;
  - round-to-nearest-even;
  - gradual underflow;
  - special-value handling (zero, Inf, NaN);
  - exception flags;
  - valid/ready streaming handshake.
- Sits between neuron-model datapath stages (e.g. weight × activation), so it must accept one operand pair per clock when downstream is ready.

---
 rtl/fmult_pipe.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/fmult_pipe.sv
// fmult_pipe: three-stage IEEE-754-style floating-point multiplier.
// Stage 1 unpacks/classifies, stage 2 multiplies mantissas and adds exponents,
// stage 3 normalises, rounds to nearest-even, handles underflow/overflow and
// packs the result with its exception flags {invalid, overflow, underflow, inexact}.
//
// Handshake: an operand pair transfers on a rising edge where in_valid && in_ready;
// a result transfers where out_valid && out_ready. The whole pipe advances together
// (adv = !out_valid | out_ready, in_ready = adv); while adv is low every stage,
// including result/flags, holds. Empty stages travel as bubbles (valid bit low).
module fmult_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] op_a,
    input  logic [EXP_W+MAN_W:0] op_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] result,
    output logic [3:0]           flags
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int MW = MAN_W + 1;            // mantissa including hidden bit
    localparam int PW = 2 * MAN_W + 2;        // full product width
    localparam int EW = EXP_W + 2;            // signed exponent width in stage 2
    localparam int SW = (EW > $clog2(PW) + 2) ? EW : $clog2(PW) + 2;
    localparam logic [EXP_W-1:0]     EXP_ONES = '1;
    localparam logic [W-1:0]         QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic signed [EW-1:0] BIAS_E   = EW'((2 ** (EXP_W - 1)) - 1);
    localparam logic signed [SW-1:0] ONE_S    = SW'(1);
    localparam logic signed [SW-1:0] RSH_MAX  = SW'(MAN_W + 2);
    localparam logic signed [SW-1:0] EMAX_S   = SW'((2 ** EXP_W) - 1);

    // Leading-zero count over the whole product word
    function automatic logic [SW-1:0] clz(input logic [PW-1:0] v);
        logic [SW-1:0] n;
        logic          done;
        n    = '0;
        done = 1'b0;
        for (int i = PW - 1; i >= 0; i--) begin
            if (!done) begin
                if (v[i]) done = 1'b1;
                else      n = n + 1'b1;
            end
        end
        return n;
    endfunction

    logic adv;
    logic s1_valid_q, s2_valid_q, out_valid_q;
    logic [W-1:0] result_q, result_d;
    logic [3:0]   flags_q, flags_d;

    // Stage 1 signals
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic             s1_sign_d, s1_spec_d, s1_inv_d;
    logic [W-1:0]     s1_spec_res_d;
    logic [MW-1:0]    s1_ma_d, s1_mb_d;
    logic [EXP_W-1:0] s1_ea_d, s1_eb_d;
    logic             s1_sign_q, s1_spec_q, s1_inv_q;
    logic [W-1:0]     s1_spec_res_q;
    logic [MW-1:0]    s1_ma_q, s1_mb_q;
    logic [EXP_W-1:0] s1_ea_q, s1_eb_q;

    // Stage 2 signals
    logic [PW-1:0]        s2_prod_d, s2_prod_q;
    logic signed [EW-1:0] s2_exp_d, s2_exp_q;
    logic                 s2_sign_q, s2_spec_q, s2_inv_q;
    logic [W-1:0]         s2_spec_res_q;

    // Stage 3 signals
    logic signed [SW-1:0] e0, e1, e2, lz, sh_l, sh_r, exp_f;
    logic [PW-1:0]        m0, m1, m2, lost_mask;
    logic                 sticky_sh, g, r, st, rnd_up, tiny, inexact;
    logic [MW-1:0]        mant;
    logic [MW:0]          mant_r;
    logic [MAN_W-1:0]     frac;

    assign adv       = !out_valid_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;

    assign ea     = op_a[W-2:MAN_W];
    assign eb     = op_b[W-2:MAN_W];
    assign fa     = op_a[MAN_W-1:0];
    assign fb     = op_b[MAN_W-1:0];
    assign a_zero = (ea == '0) && (fa == '0);
    assign b_zero = (eb == '0) && (fb == '0);
    assign a_inf  = (ea == EXP_ONES) && (fa == '0);
    assign b_inf  = (eb == EXP_ONES) && (fb == '0);
    assign a_nan  = (ea == EXP_ONES) && (fa != '0);
    assign b_nan  = (eb == EXP_ONES) && (fb != '0);

    // Subnormals get hidden bit 0 and effective exponent 1
    assign s1_sign_d = op_a[W-1] ^ op_b[W-1];
    assign s1_ma_d   = {ea != '0, fa};
    assign s1_mb_d   = {eb != '0, fb};
    assign s1_ea_d   = (ea == '0) ? EXP_W'(1) : ea;
    assign s1_eb_d   = (eb == '0) ? EXP_W'(1) : eb;

    // Stage 1: pick the special-case result (NaN beats 0*Inf beats Inf beats zero)
    always_comb begin
        s1_spec_d     = 1'b0;
        s1_inv_d      = 1'b0;
        s1_spec_res_d = '0;
        if (a_nan || b_nan) begin
            s1_spec_d     = 1'b1;
            s1_spec_res_d = QNAN;
        end else if ((a_zero && b_inf) || (a_inf && b_zero)) begin
            s1_spec_d     = 1'b1;
            s1_inv_d      = 1'b1;
            s1_spec_res_d = QNAN;
        end else if (a_inf || b_inf) begin
            s1_spec_d     = 1'b1;
            s1_spec_res_d = {s1_sign_d, EXP_ONES, {MAN_W{1'b0}}};
        end else if (a_zero || b_zero) begin
            s1_spec_d     = 1'b1;
            s1_spec_res_d = {s1_sign_d, {(W-1){1'b0}}};
        end
    end

    // Stage 2: exact mantissa product and unbiased-sum exponent with headroom
    assign s2_prod_d = PW'(s1_ma_q) * PW'(s1_mb_q);
    assign s2_exp_d  = $signed(EW'(s1_ea_q)) + $signed(EW'(s1_eb_q)) - BIAS_E;

    // Stage 3: normalise (hidden bit aligned to the product MSB), denormalise, RNE, pack
    always_comb begin
        e0   = s2_prod_q[PW-1] ? SW'(s2_exp_q) + ONE_S : SW'(s2_exp_q);
        m0   = s2_prod_q[PW-1] ? s2_prod_q : (s2_prod_q << 1);
        lz   = clz(m0);
        sh_l = '0;
        if (e0 > ONE_S) sh_l = (lz < e0 - ONE_S) ? lz : e0 - ONE_S;
        m1 = m0 << sh_l;
        e1 = e0 - sh_l;

        sh_r      = '0;
        lost_mask = '0;
        sticky_sh = 1'b0;
        m2        = m1;
        e2        = e1;
        if (e1 < ONE_S) begin
            sh_r      = (ONE_S - e1 > RSH_MAX) ? RSH_MAX : ONE_S - e1;
            lost_mask = ~({PW{1'b1}} << sh_r);
            sticky_sh = |(m1 & lost_mask);
            m2        = m1 >> sh_r;
            e2        = ONE_S;
        end

        mant    = m2[PW-1 -: MW];
        g       = m2[MAN_W];
        r       = m2[MAN_W-1];
        st      = (|m2[MAN_W-2:0]) | sticky_sh;
        rnd_up  = g & (r | st | mant[0]);
        mant_r  = {1'b0, mant} + (MW+1)'(rnd_up);
        tiny    = !m2[PW-1];
        inexact = g | r | st;

        if (mant_r[MW]) begin
            exp_f = e2 + ONE_S;
            frac  = mant_r[MAN_W:1];
        end else if (mant_r[MAN_W]) begin
            exp_f = e2;
            frac  = mant_r[MAN_W-1:0];
        end else begin
            exp_f = '0;
            frac  = mant_r[MAN_W-1:0];
        end

        if (s2_spec_q) begin
            result_d = s2_spec_res_q;
            flags_d  = {s2_inv_q, 3'b000};
        end else if (exp_f >= EMAX_S) begin
            result_d = {s2_sign_q, EXP_ONES, {MAN_W{1'b0}}};
            flags_d  = 4'b0101;
        end else begin
            result_d = {s2_sign_q, exp_f[EXP_W-1:0], frac};
            flags_d  = {2'b00, tiny & inexact, inexact};
        end
    end

    // Stage valid bits and output register; reset drops everything in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else if (adv) begin
            s1_valid_q  <= in_valid;
            s2_valid_q  <= s1_valid_q;
            out_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                result_q <= result_d;
                flags_q  <= flags_d;
            end
        end
    end

    // Datapath registers load only when their stage receives a valid entry
    always_ff @(posedge clk) begin
        if (adv) begin
            if (in_valid) begin
                s1_sign_q     <= s1_sign_d;
                s1_spec_q     <= s1_spec_d;
                s1_inv_q      <= s1_inv_d;
                s1_spec_res_q <= s1_spec_res_d;
                s1_ma_q       <= s1_ma_d;
                s1_mb_q       <= s1_mb_d;
                s1_ea_q       <= s1_ea_d;
                s1_eb_q       <= s1_eb_d;
            end
            if (s1_valid_q) begin
                s2_sign_q     <= s1_sign_q;
                s2_spec_q     <= s1_spec_q;
                s2_inv_q      <= s1_inv_q;
                s2_spec_res_q <= s1_spec_res_q;
                s2_prod_q     <= s2_prod_d;
                s2_exp_q      <= s2_exp_d;
            end
        end
    end
endmodule
